mem_access_unit: RTL and testbench
==================================

# mem_access_unit

Parametrised load/store engine for the MEM stage of the RV32I pipeline. It executes one aligned LB/LBU/LH/LHU/LW/SB/SH/SW per request over a byte-addressed external memory port. The port width (1/2/4 bytes) and read latency are parameters, and memory reads are pipelined. A data-cache lookup is made on every load, and every store is written through to the cache with a byte mask. It stalls the pipeline through `busy_o` and reports completion with a one-cycle `done_o`.

## Interface
- `ADDR_W`, 32, address width.
- `BUS_BYTES`, 1, memory data port width in bytes; legal values are 1, 2 and 4.
- `RD_LAT`, 1, cycles from an address being presented to its read data being valid; legal range 1..4.
- `clk` in 1: the single clock.
- `rst` in 1: reset, asynchronous and active-high.
- `req_i` in 1: access request; held with all operands stable until `done_o`.
- `we_i` in 1: 1 = store, 0 = load.
- `size_i` in 2: 00 byte, 01 half, 10 word (11 is illegal and treated as word).
- `unsigned_i` in 1: loads only; 1 selects zero-extension.
- `addr_i` in ADDR_W: byte address.
- `wdata_i` in 32: store data, taken from its low bytes.
- `busy_o` out 1: stall request, combinational, equal to `req_i & ~done_o`.
- `done_o` out 1: registered one-cycle completion pulse.
- `rdata_o` out 32: extended load result; holds its value until the next load completes.
- `misalign_o` out 1: high together with `done_o` when `addr_i` is not size-aligned.
- `mem_wr_o` out 1: memory write enable.
- `mem_a_o` out ADDR_W: memory beat address.
- `mem_dout_o` out 8·BUS_BYTES: memory write data.
- `mem_be_o` out BUS_BYTES: memory byte enables.
- `mem_din_i` in 8·BUS_BYTES: memory read data; lane 0 is the byte at `mem_a_o`.
- `dcache_re_o` out 1: cache lookup strobe.
- `dcache_raddr_o` out ADDR_W: cache lookup address.
- `dcache_hit_i` in 1: cache hit.
- `dcache_data_i` in 32: cache read data.
- `dcache_we_o` out 1: cache write pulse.
- `dcache_waddr_o` out ADDR_W: cache write address.
- `dcache_wdata_o` out 32: cache write data.
- `dcache_wmask_o` out 4: cache write byte mask.

## Operation
- **Transfer size.** N = 1/2/4 bytes. Beats B = ceil(N/BUS_BYTES). Beat k is at address `addr_i + k·BUS_BYTES`. Enabled lanes in the last beat = N − (B−1)·BUS_BYTES.
- **States.** IDLE, LOOKUP, RD, WR, DONE.
- **IDLE, request present:** on `req_i`:
  - misaligned → DONE with `misalign_o` set; no memory or cache traffic.
  - load → LOOKUP; register `dcache_re_o`=1 and `dcache_raddr_o`=addr.
  - store → WR; register beat 0 (`mem_wr_o`=1, address, data lanes, `mem_be_o`).
- **LOOKUP** (one cycle; `dcache_hit_i` is sampled only here):
  - hit → register the size-selected, extended `dcache_data_i` bytes into `rdata_o`, then go to DONE.
  - miss → present beat 0 on `mem_a_o`, then go to RD.
- **RD:** issue counter and receive counter.
  - Beat k's address is presented one cycle after beat k−1's.
  - Beat k's data is sampled RD_LAT cycles after its address was presented.
  - After the last issue, `mem_a_o` returns to 0.
  - When the last beat is received: assemble the bytes little-endian, extend (sign unless `unsigned_i`), register into `rdata_o`, then go to DONE.
  - Word loads only: also pulse `dcache_we_o` with mask 1111 and the assembled word.
- **WR:** one beat per cycle, lanes `wdata_i[8·(k·BUS_BYTES+j) +: 8]`.
  - After the last beat: `mem_wr_o`, `mem_a_o`, `mem_be_o` go to 0, then go to DONE.
  - Pulse `dcache_we_o` with `dcache_waddr_o`=addr, `dcache_wdata_o`=`wdata_i`, and mask 0001/0011/1111 by size.
- **DONE:** `done_o`=1 for exactly one cycle, then go to IDLE unconditionally. A request still high in DONE is not restarted.
- **`req_i` dropped mid-access:** the access still runs to DONE, because memory side effects must complete.
- **Reset**, including mid-access: immediately return to IDLE with every output at 0. No cache write is issued.

## Timing
- **Reset values:** every registered output is 0, including `rdata_o`, `misalign_o`, all `mem_*` and all `dcache_*` outputs. `busy_o` follows `req_i`.
- Cycle 0 is the cycle in which `req_i` first rises while in IDLE.
- **Latencies (cycle in which `done_o` is high):**
  - misaligned: cycle 1.
  - load hit: cycle 2.
  - load miss: cycle 2+B+RD_LAT.
  - store: cycle 1+B.
- **Load miss beat timing:** the address of beat k is on `mem_a_o` in cycle 2+k. Its data is sampled at the end of cycle 2+k+RD_LAT.
- **Cache write:** `dcache_we_o` is high in the same cycle as `done_o`.
- **`busy_o`:** low in the `done_o` cycle, so the pipeline advances at that edge.

## Test plan
- **LW miss.** BUS_BYTES=1, RD_LAT=1, LW at 0x100, miss. Memory bytes 0x11,0x22,0x33,0x84 → `mem_a_o` 0x100..0x103 in cycles 2..5; `done_o` in cycle 7; `rdata_o`=0x84332211; `dcache_we_o` in cycle 7 with mask 1111.
- **LB/LBU hit.** LB at 0x101 with hit and `dcache_data_i`=0x000000F0 → `done_o` in cycle 2, `rdata_o`=0xFFFFFFF0, no `mem_*` activity. Repeat with LBU → `rdata_o`=0x000000F0.
- **SH on a 2-byte port.** BUS_BYTES=2, SH 0xABCD to 0x202 → cycle 1 shows `mem_wr_o`=1, addr 0x202, dout 0xABCD, be 11; `done_o` in cycle 2; cache mask 0011.
- **Pipelined read.** BUS_BYTES=1, RD_LAT=3, LHU miss at 0x10 returning 0x80,0x90 → `done_o` in cycle 7, `rdata_o`=0x00009080, no cache write.
- **Misaligned.** LW at 0x102 → cycle 1 shows `done_o`=1 and `misalign_o`=1; `mem_a_o` stays 0 throughout.
- **Reset mid-access.** Assert `rst` during cycle 3 of an SW → outputs are 0 immediately, state is IDLE, no `dcache_we_o`. The next SW completes normally in cycle 5.

Source files
------------

// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store engine for the RV32I MEM stage.
// Runs one aligned LB/LBU/LH/LHU/LW/SB/SH/SW per request over a byte-addressed
// memory port of BUS_BYTES lanes with pipelined reads of RD_LAT cycles.
// Loads look up the data cache first; word-load misses refill it, and every
// store is written through to it with a byte mask.
// Handshake: req_i rises with operands and is held stable until done_o; the
// unit stalls the pipeline with busy_o = req_i & ~done_o, so the pipeline
// advances on the clock edge that ends the single done_o cycle. Operands are
// latched at acceptance, so dropping req_i mid-access still completes it.
module mem_access_unit #(
    parameter int ADDR_W    = 32,
    parameter int BUS_BYTES = 1,
    parameter int RD_LAT    = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req_i,
    input  logic                   we_i,
    input  logic [1:0]             size_i,
    input  logic                   unsigned_i,
    input  logic [ADDR_W-1:0]      addr_i,
    input  logic [31:0]            wdata_i,
    output logic                   busy_o,
    output logic                   done_o,
    output logic [31:0]            rdata_o,
    output logic                   misalign_o,
    output logic                   mem_wr_o,
    output logic [ADDR_W-1:0]      mem_a_o,
    output logic [8*BUS_BYTES-1:0] mem_dout_o,
    output logic [BUS_BYTES-1:0]   mem_be_o,
    input  logic [8*BUS_BYTES-1:0] mem_din_i,
    output logic                   dcache_re_o,
    output logic [ADDR_W-1:0]      dcache_raddr_o,
    input  logic                   dcache_hit_i,
    input  logic [31:0]            dcache_data_i,
    output logic                   dcache_we_o,
    output logic [ADDR_W-1:0]      dcache_waddr_o,
    output logic [31:0]            dcache_wdata_o,
    output logic [3:0]             dcache_wmask_o,
    output logic [2:0]             dbg_state_o
);

    localparam int BW = 8 * BUS_BYTES;
    localparam int SH = $clog2(BUS_BYTES);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOOKUP = 3'd1,
        S_RD     = 3'd2,
        S_WR     = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t            r_state;
    logic [1:0]        r_size;
    logic              r_uns;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic [31:0]       r_buf;
    logic [3:0]        r_cnt;     // beat on the bus (WR) or cycles spent in RD
    logic [3:0]        w_rcv;     // beat whose read data is on mem_din_i
    logic [31:0]       w_asm;     // read buffer with the current beat merged in

    function automatic logic [3:0] f_nbytes(input logic [1:0] s);
        case (s)
            2'b00:   return 4'd1;
            2'b01:   return 4'd2;
            default: return 4'd4;
        endcase
    endfunction

    function automatic logic [3:0] f_beats(input logic [1:0] s);
        return (f_nbytes(s) + 4'(BUS_BYTES - 1)) >> SH;
    endfunction

    function automatic logic f_misalign(input logic [1:0] a, input logic [1:0] s);
        case (s)
            2'b00:   return 1'b0;
            2'b01:   return a[0];
            default: return |a;
        endcase
    endfunction

    // Only the last beat of a transfer can be partially enabled.
    function automatic logic [BUS_BYTES-1:0] f_be(input logic [1:0] s, input logic [3:0] k);
        logic [3:0]           lanes;
        logic [BUS_BYTES-1:0] be;
        lanes = 4'(BUS_BYTES);
        if (k == f_beats(s) - 4'd1)
            lanes = f_nbytes(s) - ((f_beats(s) - 4'd1) << SH);
        for (int j = 0; j < BUS_BYTES; j++)
            be[j] = (4'(j) < lanes);
        return be;
    endfunction

    function automatic logic [BW-1:0] f_dout(input logic [31:0] wd, input logic [3:0] k);
        return BW'(wd >> (32'(k) << (SH + 3)));
    endfunction

    function automatic logic [31:0] f_ext(input logic [31:0] d, input logic [1:0] s, input logic u);
        case (s)
            2'b00:   return u ? {24'd0, d[7:0]}  : {{24{d[7]}}, d[7:0]};
            2'b01:   return u ? {16'd0, d[15:0]} : {{16{d[15]}}, d[15:0]};
            default: return d;
        endcase
    endfunction

    function automatic logic [3:0] f_mask(input logic [1:0] s);
        case (s)
            2'b00:   return 4'b0001;
            2'b01:   return 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [ADDR_W-1:0] f_beat_addr(input logic [ADDR_W-1:0] a, input logic [3:0] k);
        return a + (ADDR_W'(k) << SH);
    endfunction

    assign busy_o      = req_i & ~done_o;
    assign dbg_state_o = r_state;
    assign w_rcv       = r_cnt - 4'(RD_LAT);

    // Merge the lanes of the beat currently being received into the read buffer.
    always_comb begin
        w_asm = r_buf;
        for (int j = 0; j < BUS_BYTES; j++) begin
            if ((int'(w_rcv) * BUS_BYTES + j) < 4)
                w_asm[8*(int'(w_rcv)*BUS_BYTES + j) +: 8] = mem_din_i[8*j +: 8];
        end
    end

    // Access sequencer: accepts a request, drives cache and memory beats, pulses done.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= S_IDLE;
            r_size         <= 2'b00;
            r_uns          <= 1'b0;
            r_addr         <= '0;
            r_wdata        <= '0;
            r_buf          <= '0;
            r_cnt          <= '0;
            done_o         <= 1'b0;
            rdata_o        <= '0;
            misalign_o     <= 1'b0;
            mem_wr_o       <= 1'b0;
            mem_a_o        <= '0;
            mem_dout_o     <= '0;
            mem_be_o       <= '0;
            dcache_re_o    <= 1'b0;
            dcache_raddr_o <= '0;
            dcache_we_o    <= 1'b0;
            dcache_waddr_o <= '0;
            dcache_wdata_o <= '0;
            dcache_wmask_o <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_i) begin
                        r_size  <= size_i;
                        r_uns   <= unsigned_i;
                        r_addr  <= addr_i;
                        r_wdata <= wdata_i;
                        r_cnt   <= '0;
                        if (f_misalign(addr_i[1:0], size_i)) begin
                            done_o     <= 1'b1;
                            misalign_o <= 1'b1;
                            r_state    <= S_DONE;
                        end else if (we_i) begin
                            mem_wr_o   <= 1'b1;
                            mem_a_o    <= addr_i;
                            mem_dout_o <= f_dout(wdata_i, 4'd0);
                            mem_be_o   <= f_be(size_i, 4'd0);
                            r_state    <= S_WR;
                        end else begin
                            dcache_re_o    <= 1'b1;
                            dcache_raddr_o <= addr_i;
                            r_state        <= S_LOOKUP;
                        end
                    end
                end
                S_LOOKUP: begin
                    dcache_re_o    <= 1'b0;
                    dcache_raddr_o <= '0;
                    r_cnt          <= '0;
                    if (dcache_hit_i) begin
                        rdata_o <= f_ext(dcache_data_i, r_size, r_uns);
                        done_o  <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        mem_a_o <= r_addr;
                        r_state <= S_RD;
                    end
                end
                S_RD: begin
                    r_cnt <= r_cnt + 4'd1;
                    if (r_cnt + 4'd1 < f_beats(r_size))
                        mem_a_o <= f_beat_addr(r_addr, r_cnt + 4'd1);
                    else
                        mem_a_o <= '0;
                    if (r_cnt >= 4'(RD_LAT)) begin
                        r_buf <= w_asm;
                        if (w_rcv == f_beats(r_size) - 4'd1) begin
                            rdata_o <= f_ext(w_asm, r_size, r_uns);
                            done_o  <= 1'b1;
                            r_state <= S_DONE;
                            if (r_size[1]) begin
                                dcache_we_o    <= 1'b1;
                                dcache_waddr_o <= r_addr;
                                dcache_wdata_o <= w_asm;
                                dcache_wmask_o <= 4'b1111;
                            end
                        end
                    end
                end
                S_WR: begin
                    if (r_cnt == f_beats(r_size) - 4'd1) begin
                        mem_wr_o       <= 1'b0;
                        mem_a_o        <= '0;
                        mem_dout_o     <= '0;
                        mem_be_o       <= '0;
                        dcache_we_o    <= 1'b1;
                        dcache_waddr_o <= r_addr;
                        dcache_wdata_o <= r_wdata;
                        dcache_wmask_o <= f_mask(r_size);
                        done_o         <= 1'b1;
                        r_state        <= S_DONE;
                    end else begin
                        r_cnt      <= r_cnt + 4'd1;
                        mem_a_o    <= f_beat_addr(r_addr, r_cnt + 4'd1);
                        mem_dout_o <= f_dout(r_wdata, r_cnt + 4'd1);
                        mem_be_o   <= f_be(r_size, r_cnt + 4'd1);
                    end
                end
                S_DONE: begin
                    done_o         <= 1'b0;
                    misalign_o     <= 1'b0;
                    dcache_we_o    <= 1'b0;
                    dcache_waddr_o <= '0;
                    dcache_wdata_o <= '0;
                    dcache_wmask_o <= '0;
                    r_state        <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: four instances with different port widths and
// read latencies share one byte memory image and one cache stimulus. Each
// operation is expanded into a per-cycle expected trace from the access rules
// and checked at every negedge while the operation is in flight.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req = 4'd0;
    logic        we = 1'b0;
    logic [1:0]  size = 2'b00;
    logic        uns = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic        c_hit = 1'b0;
    logic [31:0] c_data = '0;

    logic [3:0]  busy_v, done_v, mis_v, mwr_v, cre_v, cwe_v;
    logic [31:0] rdata_v [4];
    logic [31:0] ma_v [4];
    logic [31:0] mdout_v [4];
    logic [3:0]  mbe_v [4];
    logic [31:0] raddr_v [4];
    logic [31:0] waddr_v [4];
    logic [31:0] cwdata_v [4];
    logic [3:0]  wmask_v [4];
    logic [2:0]  st_v [4];

    logic [7:0]  mem_bytes [0:1023];
    logic [31:0] prev_rd [4];

    int n_chk = 0;
    int n_fail = 0;
    int chk_inst = 0;
    int chk_cyc = 0;

    typedef struct {
        int          inst;
        int          cyc;
        logic        busy, done, mis, mwr, cre, cwe;
        logic [31:0] ma, mdout, raddr, waddr, wdata, rdata;
        logic [3:0]  mbe, wmask;
    } exp_t;

    exp_t exp_q[$];
    exp_t ce;

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int cfg_bb(input int g);
        return (g == 1) ? 2 : (g == 3) ? 4 : 1;
    endfunction

    // ---------------- DUTs and memory models ----------------
    for (genvar g = 0; g < 4; g++) begin : g_dut
        localparam int BB  = (g == 1) ? 2 : (g == 3) ? 4 : 1;
        localparam int LAT = g + 1;
        logic [8*BB-1:0] w_dout, w_din;
        logic [BB-1:0]   w_be;
        logic [31:0]     w_a;
        logic [31:0]     a_pipe [0:3];

        mem_access_unit #(.ADDR_W(32), .BUS_BYTES(BB), .RD_LAT(LAT)) u_dut (
            .clk(clk), .rst(rst), .req_i(req[g]), .we_i(we), .size_i(size),
            .unsigned_i(uns), .addr_i(addr), .wdata_i(wdata),
            .busy_o(busy_v[g]), .done_o(done_v[g]), .rdata_o(rdata_v[g]),
            .misalign_o(mis_v[g]), .mem_wr_o(mwr_v[g]), .mem_a_o(w_a),
            .mem_dout_o(w_dout), .mem_be_o(w_be), .mem_din_i(w_din),
            .dcache_re_o(cre_v[g]), .dcache_raddr_o(raddr_v[g]),
            .dcache_hit_i(c_hit), .dcache_data_i(c_data),
            .dcache_we_o(cwe_v[g]), .dcache_waddr_o(waddr_v[g]),
            .dcache_wdata_o(cwdata_v[g]), .dcache_wmask_o(wmask_v[g]),
            .dbg_state_o(st_v[g])
        );

        assign ma_v[g]    = w_a;
        assign mdout_v[g] = 32'(w_dout);
        assign mbe_v[g]   = 4'(w_be);

        // Memory returns the bytes addressed LAT cycles earlier.
        always @(posedge clk) begin
            a_pipe[0] <= w_a;
            for (int i = 1; i < 4; i++) a_pipe[i] <= a_pipe[i-1];
        end

        always @* begin
            for (int j = 0; j < BB; j++)
                w_din[8*j +: 8] = mem_bytes[10'(a_pipe[LAT-1] + 32'(j))];
        end
    end

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s inst%0d cyc%0d: got %h want %h", name, chk_inst, chk_cyc, act, exp);
        end
    endtask

    task automatic check_zero(input int g);
        chk_inst = g;
        check("rst_done", 32'(done_v[g]), 0);
        check("rst_misalign", 32'(mis_v[g]), 0);
        check("rst_mem_wr", 32'(mwr_v[g]), 0);
        check("rst_mem_a", ma_v[g], 0);
        check("rst_mem_dout", mdout_v[g], 0);
        check("rst_mem_be", 32'(mbe_v[g]), 0);
        check("rst_dc_re", 32'(cre_v[g]), 0);
        check("rst_dc_raddr", raddr_v[g], 0);
        check("rst_dc_we", 32'(cwe_v[g]), 0);
        check("rst_dc_waddr", waddr_v[g], 0);
        check("rst_dc_wdata", cwdata_v[g], 0);
        check("rst_dc_wmask", 32'(wmask_v[g]), 0);
        check("rst_rdata", rdata_v[g], 0);
        check("rst_state_idle", 32'(st_v[g]), 0);
    endtask

    function automatic logic [31:0] ext(input logic [31:0] d, input logic [1:0] sz, input logic u);
        if (sz == 2'b00) return u ? (d & 32'hFF) : 32'($signed(d[7:0]));
        if (sz == 2'b01) return u ? (d & 32'hFFFF) : 32'($signed(d[15:0]));
        return d;
    endfunction

    // ---------------- scoreboard compare ----------------
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            ce = exp_q.pop_front();
            chk_inst = ce.inst;
            chk_cyc = ce.cyc;
            check("busy", 32'(busy_v[ce.inst]), 32'(ce.busy));
            check("done", 32'(done_v[ce.inst]), 32'(ce.done));
            check("misalign", 32'(mis_v[ce.inst]), 32'(ce.mis));
            check("mem_wr", 32'(mwr_v[ce.inst]), 32'(ce.mwr));
            check("mem_a", ma_v[ce.inst], ce.ma);
            check("mem_be", 32'(mbe_v[ce.inst]), 32'(ce.mbe));
            if (ce.mwr) check("mem_dout", mdout_v[ce.inst], ce.mdout);
            check("dc_re", 32'(cre_v[ce.inst]), 32'(ce.cre));
            if (ce.cre) check("dc_raddr", raddr_v[ce.inst], ce.raddr);
            check("dc_we", 32'(cwe_v[ce.inst]), 32'(ce.cwe));
            if (ce.cwe) begin
                check("dc_waddr", waddr_v[ce.inst], ce.waddr);
                check("dc_wdata", cwdata_v[ce.inst], ce.wdata);
                check("dc_wmask", 32'(wmask_v[ce.inst]), 32'(ce.wmask));
            end
            check("rdata", rdata_v[ce.inst], ce.rdata);
        end
    end

    // ---------------- driver: one access with its expected trace ----------------
    task automatic run_op(input int g, input logic w, input logic [1:0] sz, input logic u,
                          input logic [31:0] a, input logic [31:0] wd, input logic hit,
                          input logic [31:0] cd, input logic drop, input int exp_lat);
        int n, bb, nb, lanes, d, seen, k;
        logic mis, ld;
        logic [31:0] raw, new_rd, bmask;
        exp_t e;
        bb = cfg_bb(g);
        n = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
        nb = (n + bb - 1) / bb;
        lanes = n - (nb - 1) * bb;
        bmask = (bb == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * bb)) - 1);
        mis = (a % n) != 0;
        ld = !w && !mis;
        raw = '0;
        if (hit) raw = cd;
        else for (int i = 0; i < n; i++) raw[8*i +: 8] = mem_bytes[10'(a + 32'(i))];
        new_rd = ext(raw, sz, u);
        if (mis) d = 1;
        else if (w) d = 1 + nb;
        else if (hit) d = 2;
        else d = 2 + nb + (g + 1);

        @(posedge clk); #1;
        we = w; size = sz; uns = u; addr = a; wdata = wd; c_hit = hit; c_data = cd;
        req[g] = 1'b1;
        for (int c = 0; c <= d; c++) begin
            e = '{default: '0};
            e.inst = g;
            e.cyc = c;
            e.busy = drop ? (c == 0) : (c < d);
            e.done = (c == d);
            e.rdata = (c == d && ld) ? new_rd : prev_rd[g];
            if (mis && c == 1) e.mis = 1'b1;
            if (ld && c == 1) begin e.cre = 1'b1; e.raddr = a; end
            if (ld && !hit && c >= 2 && c < 2 + nb) e.ma = a + 32'((c - 2) * bb);
            if (ld && !hit && n == 4 && c == d) begin
                e.cwe = 1'b1; e.waddr = a; e.wdata = raw; e.wmask = 4'hF;
            end
            if (w && !mis && c >= 1 && c <= nb) begin
                k = c - 1;
                e.mwr = 1'b1;
                e.ma = a + 32'(k * bb);
                e.mdout = (wd >> (8 * k * bb)) & bmask;
                e.mbe = (k < nb - 1) ? 4'(bmask[3:0] & ((4'h1 << bb) - 4'h1)) : 4'((4'h1 << lanes) - 4'h1);
            end
            if (w && !mis && c == d) begin
                e.cwe = 1'b1; e.waddr = a; e.wdata = wd;
                e.wmask = (n == 1) ? 4'h1 : (n == 2) ? 4'h3 : 4'hF;
            end
            exp_q.push_back(e);
        end

        seen = -1;
        for (int c = 0; c <= d; c++) begin
            @(negedge clk);
            if (done_v[g] && seen < 0) seen = c;
            @(posedge clk); #1;
            if (c == 0 && drop) req[g] = 1'b0;
            if (c == 1) begin c_hit = ~hit; c_data = $urandom; end
            if (c == d) req[g] = 1'b0;
        end
        if (exp_lat >= 0) begin
            chk_inst = g;
            chk_cyc = seen;
            check("done_cycle", 32'(seen), 32'(exp_lat));
        end
        if (ld) prev_rd[g] = new_rd;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int g, n;
        logic [1:0] sz;
        logic [31:0] a;
        for (int i = 0; i < 1024; i++) mem_bytes[i] = 8'($urandom);
        for (int i = 0; i < 4; i++) prev_rd[i] = '0;

        // Reset state; busy follows req even in reset.
        req = 4'hF;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            check_zero(i);
            check("rst_busy", 32'(busy_v[i]), 1);
        end
        req = 4'h0;
        @(negedge clk);
        rst = 1'b0;

        // LW miss on the 1-byte port, RD_LAT=1.
        mem_bytes[10'h100] = 8'h11; mem_bytes[10'h101] = 8'h22;
        mem_bytes[10'h102] = 8'h33; mem_bytes[10'h103] = 8'h84;
        run_op(0, 1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 1'b0, 32'h0, 1'b0, 7);
        chk_inst = 0; check("lw_miss_rdata", rdata_v[0], 32'h8433_2211);

        // LB / LBU hits.
        run_op(0, 1'b0, 2'b00, 1'b0, 32'h101, 32'h0, 1'b1, 32'h0000_00F0, 1'b0, 2);
        chk_inst = 0; check("lb_hit_rdata", rdata_v[0], 32'hFFFF_FFF0);
        run_op(0, 1'b0, 2'b00, 1'b1, 32'h101, 32'h0, 1'b1, 32'h0000_00F0, 1'b0, 2);
        chk_inst = 0; check("lbu_hit_rdata", rdata_v[0], 32'h0000_00F0);

        // SH on the 2-byte port.
        run_op(1, 1'b1, 2'b01, 1'b0, 32'h202, 32'h0000_ABCD, 1'b0, 32'h0, 1'b0, 2);

        // Pipelined LHU miss, RD_LAT=3.
        mem_bytes[10'h010] = 8'h80; mem_bytes[10'h011] = 8'h90;
        run_op(2, 1'b0, 2'b01, 1'b1, 32'h10, 32'h0, 1'b0, 32'h0, 1'b0, 7);
        chk_inst = 2; check("lhu_pipe_rdata", rdata_v[2], 32'h0000_9080);

        // Misaligned LW.
        run_op(0, 1'b0, 2'b10, 1'b0, 32'h102, 32'h0, 1'b1, 32'h1234_5678, 1'b0, 1);

        // Reset during cycle 3 of an SW on the 1-byte port.
        @(posedge clk); #1;
        we = 1'b1; size = 2'b10; uns = 1'b0; addr = 32'h40; wdata = 32'hDEAD_BEEF;
        req[0] = 1'b1;
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check_zero(0);
        chk_inst = 0; check("rst_mid_busy", 32'(busy_v[0]), 1);
        @(posedge clk); #1;
        req[0] = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) prev_rd[i] = '0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk_inst = 0; chk_cyc = i;
            check("post_rst_dc_we", 32'(cwe_v[0]), 0);
            check("post_rst_done", 32'(done_v[0]), 0);
        end
        run_op(0, 1'b1, 2'b10, 1'b0, 32'h40, 32'hDEAD_BEEF, 1'b0, 32'h0, 1'b0, 5);

        // Randomized accesses across all port configurations.
        for (int t = 0; t < 60; t++) begin
            g = $urandom_range(0, 3);
            sz = 2'($urandom_range(0, 3));
            n = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
            a = 32'($urandom_range(0, 1016));
            if ($urandom_range(0, 4) != 0) a = a & ~(32'(n) - 32'd1);
            run_op(g, 1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom,
                   1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 3) == 0), -1);
        end

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
